// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked arbiter sharing one baud-timed 8N1 UART serializer among NUM_REQ byte lanes.
// Define UART_ARB_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [8*NUM_REQ-1:0]       i_data,
  output logic [NUM_REQ-1:0]         o_ack,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy,
  output logic                       o_tx,
  output logic [2:0]                 dbg_state
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shreg, shreg_n;
  logic [7:0]     burst_cnt, burst_n;
  logic [IW-1:0]  ptr, ptr_n;
  logic [NUM_REQ-1:0] ack_n, grant_n;
  logic [IW-1:0]  grant_id_n;
  logic           busy_n, tx_n;

  logic           bit_end, arb_point, owner_keep, rr_found, win_valid;
  logic [IW-1:0]  rr_id, win_id;

  assign dbg_state = state;
  assign bit_end   = (cnt == CNT_LAST);
  assign arb_point = (state == S_IDLE) || ((state == S_STOP) && bit_end);

  // An owner exists only while a frame is in flight; a grant from IDLE always starts a fresh burst.
  assign owner_keep = (|o_grant) && i_req[o_grant_id] && (burst_cnt < 8'(MAX_BURST));
  assign win_valid  = owner_keep || rr_found;
  assign win_id     = owner_keep ? o_grant_id : rr_id;

  always_comb begin : rr_search
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rr_found && i_req[IW'(idx)]) begin
        rr_found = 1'b1;
        rr_id    = IW'(idx);
      end
    end
  end

  // Handshake: i_req[i] is valid for lane i; the byte transfers on the edge that raises o_ack[i]
  // (one cycle), and the requester must present its next byte or drop i_req before the next arbitration.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    burst_n    = burst_cnt;
    ptr_n      = ptr;
    ack_n      = '0;
    grant_n    = o_grant;
    grant_id_n = o_grant_id;
    busy_n     = o_busy;
    tx_n       = o_tx;
    if (state != S_IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;

    case (state)
      S_START: if (bit_end) begin
        state_n   = S_DATA;
        bit_idx_n = 3'd0;
        tx_n      = shreg[0];
      end
      S_DATA: if (bit_end) begin
        if (bit_idx == 3'd7) begin
`ifdef UART_ARB_PARITY_EN
          state_n = S_PARITY;
          tx_n    = ^shreg;
`else
          state_n = S_STOP;
          tx_n    = 1'b1;
`endif
        end else begin
          bit_idx_n = bit_idx + 3'd1;
          tx_n      = shreg[bit_idx + 3'd1];
        end
      end
`ifdef UART_ARB_PARITY_EN
      S_PARITY: if (bit_end) begin
        state_n = S_STOP;
        tx_n    = 1'b1;
      end
`endif
      default: ;
    endcase

    if (arb_point) begin
      if (win_valid) begin
        state_n    = S_START;
        cnt_n      = '0;
        tx_n       = 1'b0;
        shreg_n    = i_data[8*int'(win_id) +: 8];
        ack_n      = NUM_REQ'(1) << win_id;
        grant_n    = NUM_REQ'(1) << win_id;
        grant_id_n = win_id;
        busy_n     = 1'b1;
        burst_n    = owner_keep ? burst_cnt + 8'd1 : 8'd1;
        ptr_n      = (win_id == IW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      end else if (state == S_STOP) begin
        state_n = S_IDLE;
        cnt_n   = '0;
        grant_n = '0;
        busy_n  = 1'b0;
        tx_n    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
      burst_cnt  <= 8'd0;
      ptr        <= '0;
      o_ack      <= '0;
      o_grant    <= '0;
      o_grant_id <= '0;
      o_busy     <= 1'b0;
      o_tx       <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      burst_cnt  <= burst_n;
      ptr        <= ptr_n;
      o_ack      <= ack_n;
      o_grant    <= grant_n;
      o_grant_id <= grant_id_n;
      o_busy     <= busy_n;
      o_tx       <= tx_n;
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmitter among `NUM_REQ` byte-stream requesters using round-robin arbitration with bounded burst locking. The block contains the baud-timed serializer, so it drives the board TX pin directly. It pairs with the existing `uart_rx` receive path: RX feeds detectors and logic, and this block returns status and echo bytes to the host.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (115200 baud at 50 MHz).
- `NUM_REQ`, 4, number of requesters (2..8).
- `MAX_BURST`, 8, maximum consecutive bytes granted to one requester while another requester is waiting (1..255).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `i_req`  input  NUM_REQ  per-requester byte-pending flag; held high while the byte on its lane is valid.
- `i_data`  input  8*NUM_REQ  byte lanes; lane i is bits [8i+7:8i].
- `o_ack`  output  NUM_REQ  one-cycle pulse when lane i's byte is captured.
- `o_grant`  output  NUM_REQ  one-hot owner of the current frame; all zero when idle.
- `o_grant_id`  output  $clog2(NUM_REQ)  index of the current or most recent owner.
- `o_busy`  output  1  high while a frame is being shifted.
- `o_tx`  output  1  serial line; idles high.

## Operation
- States: IDLE, START, DATA, PARITY (only when the parity macro is defined), STOP.
- **Arbitration.** Arbitration runs in IDLE and in the last cycle of STOP.
  - The candidate is the first `i_req` bit searching upward, with wrap-around, from `ptr`. `ptr` is initially `last_owner+1`.
  - Burst lock: if the current owner still has `i_req` high and `burst_cnt < MAX_BURST`, the owner keeps the grant.
  - If the owner's burst limit is reached but no other requester is pending, the owner keeps the grant and `burst_cnt` restarts at 1.
- **Capture.** On a grant, the selected lane's byte is latched into the shift register. `o_ack[i]` pulses for exactly one cycle. `burst_cnt` is incremented, or set to 1 on an owner change. The FSM then enters START.
- **Requester rule.** After seeing `o_ack`, the requester has until the next arbitration point to present its next byte or drop `i_req`.
  - Dropping `i_req` mid-frame never aborts the byte in flight.
  - `i_data` is not sampled after capture.
- **Frame format.** Start bit 0, then data LSB first through `bit_idx` 0..7, then stop bit 1. Each bit lasts `CLKS_PER_BIT` cycles, timed by a counter running 0..CLKS_PER_BIT-1.
- **End of frame.**
  - No request pending at the last STOP cycle: go to IDLE; `o_grant` becomes 0 and `o_busy` becomes 0.
  - A request is pending: go directly to START of the next frame, with no idle gap.
- **Reset values:** `o_tx`=1, `o_ack`=0, `o_grant`=0, `o_grant_id`=0, `o_busy`=0, `ptr`=0, `burst_cnt`=0, state=IDLE.
- **Reset mid-frame:** `o_tx` returns to 1 asynchronously and the partial byte is discarded. No further `o_ack` is issued for that byte.

## Timing
- **Request to start bit.** If `i_req[i]` is sampled high in IDLE at edge k, then from edge k:
  - `o_ack[i]` is high for one cycle;
  - `o_grant[i]` is high;
  - `o_busy` is high;
  - `o_tx` is 0.
- **Frame length:** 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- **Back-to-back frames:** the next start bit begins on the edge right after the final stop cycle. The next `o_ack` coincides with that edge.
- All outputs are registered. There are no combinational paths from input to output.
- **Simultaneous events:** requests arriving together are resolved by `ptr` in a single cycle. A request arriving in the last STOP cycle is included in that arbitration.

## Configuration
- `UART_ARB_PARITY_EN` defined: a PARITY state is inserted after DATA. It drives the even-parity bit, the XOR of the 8 data bits, for `CLKS_PER_BIT` cycles. The frame is 11 bits.
- `UART_ARB_PARITY_EN` undefined: there is no PARITY state and the frame is 8N1. All other behaviour is identical.

## Test plan
- **Reset and idle.** Assert `rst` mid-stream. Required: `o_tx`=1, `o_ack`=0, `o_grant`=0 immediately; no stray ack after `rst` deasserts.
- **Single byte.** `CLKS_PER_BIT`=4. `i_req[0]`=1 with lane 0 = 0xA5. Required: ack pulses at edge 1. `o_tx` reads 0, then 1,0,1,0,0,1,0,1, then 1, each level for 4 cycles. `o_busy` is high for 40 cycles.
- **Round-robin.** All four requesters hold `i_req` with `MAX_BURST`=1. Required: grants in order 0,1,2,3,0, with no idle gap between frames.
- **Burst lock.** Requester 2 streams 12 bytes while requester 0 waits, `MAX_BURST`=8. Required: 8 frames to requester 2, then 1 frame to requester 0, then the remaining 4 frames to requester 2.
- **Request drop.** Requester 1 drops `i_req` in the cycle after its ack. Required: its byte completes intact, then the FSM returns to IDLE with `o_grant`=0.
- **Parity.** With `UART_ARB_PARITY_EN` defined, send 0x07. Required: parity bit is 1, the frame is 44 cycles at `CLKS_PER_BIT`=4, and the stop bit follows.
